// File: rtl/n101_subsys_excl_mon_pkg.sv
// Shared constants for the exclusive-access monitor slice: address/data widths
// and the default reservation lifetime.
package n101_subsys_excl_mon_pkg;

  localparam int N101_ADDR_SIZE    = 32;
  localparam int N101_XLEN         = 32;
  localparam int N101_EXCL_TMO_CYC = 64;

endpackage

// File: rtl/n101_excl_mon_entry.sv
// One reservation entry: valid bit plus granule address, set by LR and cleared
// by conflicting writes/SC. With N101_EXCL_TIMEOUT_EN an age counter expires it.
module n101_excl_mon_entry #(
  parameter int GRAN_W = 30
`ifdef N101_EXCL_TIMEOUT_EN
  , parameter int TMO_CYC = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_i,
  input  logic              clr_i,
  input  logic [GRAN_W-1:0] gran_i,
  output logic              match_o
);

  logic              valid_q, valid_d;
  logic [GRAN_W-1:0] gran_q, gran_d;
  logic              expire;

`ifdef N101_EXCL_TIMEOUT_EN
  localparam int CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = valid_q & (cnt_q == CNT_W'(TMO_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (set_i) begin
      cnt_d = '0;
    end else if (valid_q && !expire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  // Set wins over both command clears and timeout expiry.
  always_comb begin
    valid_d = valid_q;
    gran_d  = gran_q;
    if (set_i) begin
      valid_d = 1'b1;
      gran_d  = gran_i;
    end else if (clr_i || expire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      gran_q  <= '0;
    end else begin
      valid_q <= valid_d;
      gran_q  <= gran_d;
    end
  end

  assign match_o = valid_q & (gran_q == gran_i);

endmodule

// File: rtl/n101_gnrl_fifo.sv
// Generic valid/ready FIFO. CUT_READY=0 lets a full FIFO accept a push in the
// same cycle as a pop; MSKO=1 forces the output data to zero while empty.
module n101_gnrl_fifo #(
  parameter int CUT_READY = 0,
  parameter int MSKO      = 0,
  parameter int DW        = 1,
  parameter int DP        = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat
);

  localparam int PW = (DP > 1) ? $clog2(DP) : 1;
  localparam int CW = $clog2(DP + 1);

  logic [DW-1:0] mem_q [DP];
  logic [DW-1:0] mem_d [DP];
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty, push, pop;

  assign full  = (cnt_q == CW'(DP));
  assign empty = (cnt_q == '0);
  assign o_vld = ~empty;
  assign pop   = o_vld & o_rdy;
  assign i_rdy = (CUT_READY != 0) ? ~full : (~full | pop);
  assign push  = i_vld & i_rdy;
  assign o_dat = ((MSKO != 0) && empty) ? '0 : mem_q[rptr_q];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[wptr_q] = i_dat;
      wptr_d = (wptr_q == PW'(DP - 1)) ? '0 : wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PW'(DP - 1)) ? '0 : rptr_q + PW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DP; i++) mem_q[i] <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/n101_subsys_excl_mon.sv
// ICB exclusive-access monitor: tracks LR reservations per master, kills false
// SC writes and returns in-order excl_ok flags. Timeout option: N101_EXCL_TIMEOUT_EN.
module n101_subsys_excl_mon
  import n101_subsys_excl_mon_pkg::*;
#(
  parameter int NUM_MST  = 4,
  parameter int ID_W     = 2,
  parameter int GRAN_LSB = 2,
  parameter int OST_DP   = 2,
  parameter int TMO_CYC  = N101_EXCL_TMO_CYC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      icb_cmd_valid,
  output logic                      icb_cmd_ready,
  input  logic [N101_ADDR_SIZE-1:0] icb_cmd_addr,
  input  logic                      icb_cmd_read,
  input  logic [N101_XLEN-1:0]      icb_cmd_wdata,
  input  logic [N101_XLEN/8-1:0]    icb_cmd_wmask,
  input  logic                      icb_cmd_lock,
  input  logic                      icb_cmd_excl,
  input  logic [1:0]                icb_cmd_size,
  input  logic [ID_W-1:0]           icb_cmd_id,
  output logic                      icb_rsp_valid,
  input  logic                      icb_rsp_ready,
  output logic                      icb_rsp_err,
  output logic                      icb_rsp_excl_ok,
  output logic [N101_XLEN-1:0]      icb_rsp_rdata,
  output logic                      o_icb_cmd_valid,
  input  logic                      o_icb_cmd_ready,
  output logic [N101_ADDR_SIZE-1:0] o_icb_cmd_addr,
  output logic                      o_icb_cmd_read,
  output logic [N101_XLEN-1:0]      o_icb_cmd_wdata,
  output logic [N101_XLEN/8-1:0]    o_icb_cmd_wmask,
  output logic                      o_icb_cmd_lock,
  output logic [1:0]                o_icb_cmd_size,
  input  logic                      o_icb_rsp_valid,
  output logic                      o_icb_rsp_ready,
  input  logic                      o_icb_rsp_err,
  input  logic [N101_XLEN-1:0]      o_icb_rsp_rdata
);

  localparam int              GRAN_W    = N101_ADDR_SIZE - GRAN_LSB;
  localparam logic [ID_W:0]   NUM_MST_C = (ID_W + 1)'(NUM_MST);

  if (NUM_MST > (1 << ID_W) || TMO_CYC < 2) begin : g_cfg_err
    $error("n101_subsys_excl_mon: NUM_MST must fit ID_W and TMO_CYC must be >= 2");
  end

  logic [GRAN_W-1:0]  cmd_gran;
  logic               id_ok, is_lr, is_sc, plain_wr;
  logic               own_match, sc_true, hs;
  logic               fifo_i_rdy, fifo_not_full, fifo_o_vld, fifo_head;
  logic [NUM_MST-1:0] ent_match, ent_set, ent_clr;

  assign cmd_gran = icb_cmd_addr[N101_ADDR_SIZE-1:GRAN_LSB];
  assign id_ok    = ({1'b0, icb_cmd_id} < NUM_MST_C);
  assign is_lr    = icb_cmd_read & icb_cmd_excl;
  assign is_sc    = ~icb_cmd_read & icb_cmd_excl;
  assign plain_wr = ~icb_cmd_read & ~icb_cmd_excl;

  // Reset gates the command path so nothing is accepted while rst_n is low.
  assign fifo_not_full   = fifo_i_rdy & rst_n;
  assign icb_cmd_ready   = o_icb_cmd_ready & fifo_not_full;
  assign o_icb_cmd_valid = icb_cmd_valid & fifo_not_full;
  assign hs              = icb_cmd_valid & icb_cmd_ready;

  always_comb begin
    own_match = 1'b0;
    for (int k = 0; k < NUM_MST; k++) begin
      if (icb_cmd_id == ID_W'(k)) own_match = ent_match[k];
    end
  end

  assign sc_true = is_sc & id_ok & own_match;

  always_comb begin
    ent_set = '0;
    ent_clr = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      ent_set[k] = hs & is_lr & (icb_cmd_id == ID_W'(k));
      ent_clr[k] = hs & ((((plain_wr | sc_true) & ent_match[k])) |
                         (is_sc & (icb_cmd_id == ID_W'(k))));
    end
  end

  for (genvar k = 0; k < NUM_MST; k++) begin : g_entry
    n101_excl_mon_entry #(
      .GRAN_W (GRAN_W)
`ifdef N101_EXCL_TIMEOUT_EN
      , .TMO_CYC(TMO_CYC)
`endif
    ) u_entry (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_i   (ent_set[k]),
      .clr_i   (ent_clr[k]),
      .gran_i  (cmd_gran),
      .match_o (ent_match[k])
    );
  end

  n101_gnrl_fifo #(
    .CUT_READY (0),
    .MSKO      (0),
    .DW        (1),
    .DP        (OST_DP)
  ) u_flag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (icb_cmd_valid & o_icb_cmd_ready),
    .i_rdy (fifo_i_rdy),
    .i_dat (sc_true),
    .o_vld (fifo_o_vld),
    .o_rdy (o_icb_rsp_valid & icb_rsp_ready),
    .o_dat (fifo_head)
  );

  assign o_icb_cmd_addr  = icb_cmd_addr;
  assign o_icb_cmd_read  = icb_cmd_read;
  assign o_icb_cmd_wdata = icb_cmd_wdata;
  assign o_icb_cmd_lock  = icb_cmd_lock;
  assign o_icb_cmd_size  = icb_cmd_size;
  assign o_icb_cmd_wmask = (is_sc & ~sc_true) ? '0 : icb_cmd_wmask;

  assign icb_rsp_valid   = o_icb_rsp_valid;
  assign icb_rsp_err     = o_icb_rsp_err;
  assign icb_rsp_rdata   = o_icb_rsp_rdata;
  assign o_icb_rsp_ready = icb_rsp_ready;
  assign icb_rsp_excl_ok = fifo_o_vld & fifo_head & ~o_icb_rsp_err;

endmodule

// File: tb/tb_n101_subsys_excl_mon.sv
// Self-checking bench for n101_subsys_excl_mon: directed scenarios with literal
// expectations plus randomized traffic checked against a reservation model.
module tb_n101_subsys_excl_mon;

  localparam int NUM_MST = 3;
  localparam int ID_W    = 2;
  localparam int OST_DP  = 2;
  localparam int TMO_CYC = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read, icb_cmd_lock, icb_cmd_excl;
  logic [31:0] icb_cmd_addr, icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic [1:0]  icb_cmd_size;
  logic [1:0]  icb_cmd_id;
  logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err, icb_rsp_excl_ok;
  logic [31:0] icb_rsp_rdata;
  logic        o_icb_cmd_valid, o_icb_cmd_ready, o_icb_cmd_read, o_icb_cmd_lock;
  logic [31:0] o_icb_cmd_addr, o_icb_cmd_wdata;
  logic [3:0]  o_icb_cmd_wmask;
  logic [1:0]  o_icb_cmd_size;
  logic        o_icb_rsp_valid, o_icb_rsp_ready, o_icb_rsp_err;
  logic [31:0] o_icb_rsp_rdata;

  int tests = 0;
  int fails = 0;

  n101_subsys_excl_mon #(
    .NUM_MST(NUM_MST), .ID_W(ID_W), .GRAN_LSB(2), .OST_DP(OST_DP), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_cmd_lock(icb_cmd_lock), .icb_cmd_excl(icb_cmd_excl),
    .icb_cmd_size(icb_cmd_size), .icb_cmd_id(icb_cmd_id),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_err(icb_rsp_err), .icb_rsp_excl_ok(icb_rsp_excl_ok),
    .icb_rsp_rdata(icb_rsp_rdata),
    .o_icb_cmd_valid(o_icb_cmd_valid), .o_icb_cmd_ready(o_icb_cmd_ready),
    .o_icb_cmd_addr(o_icb_cmd_addr), .o_icb_cmd_read(o_icb_cmd_read),
    .o_icb_cmd_wdata(o_icb_cmd_wdata), .o_icb_cmd_wmask(o_icb_cmd_wmask),
    .o_icb_cmd_lock(o_icb_cmd_lock), .o_icb_cmd_size(o_icb_cmd_size),
    .o_icb_rsp_valid(o_icb_rsp_valid), .o_icb_rsp_ready(o_icb_rsp_ready),
    .o_icb_rsp_err(o_icb_rsp_err), .o_icb_rsp_rdata(o_icb_rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic rd, input logic ex,
                               input logic [31:0] a, input logic [1:0] id,
                               input logic [3:0] wm, input logic ordy,
                               input logic rspv, input logic rspr, input logic err);
    @(negedge clk);
    icb_cmd_valid   = v;
    icb_cmd_read    = rd;
    icb_cmd_excl    = ex;
    icb_cmd_addr    = a;
    icb_cmd_id      = id;
    icb_cmd_wmask   = wm;
    icb_cmd_wdata   = $urandom;
    icb_cmd_lock    = 1'($urandom_range(0, 1));
    icb_cmd_size    = 2'($urandom_range(0, 2));
    o_icb_cmd_ready = ordy;
    o_icb_rsp_valid = rspv;
    icb_rsp_ready   = rspr;
    o_icb_rsp_err   = err;
    o_icb_rsp_rdata = $urandom;
  endtask

  task automatic cmd(input logic rd, input logic ex, input logic [31:0] a,
                     input logic [1:0] id, input logic [3:0] wm);
    applyStimulus(1'b1, rd, ex, a, id, wm, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic rsp(input logic err);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 4'h0, 1'b1, 1'b1, 1'b1, err);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  // Reservation model: per-master valid/granule/age, plus a queue of flags
  // for commands handed downstream but not yet answered.
  bit          m_valid [4];
  logic [29:0] m_gran  [4];
  int          m_age   [4];
  bit          mq[$];
  bit          m_pop, m_acc, m_hs, m_sct, m_rd, m_ex;
  logic [29:0] m_g;
  int          m_id;

  always begin : compare_proc
    @(negedge clk);
    #2;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
      mq.delete();
      checkOutput("rst_cmd_ready", 32'(icb_cmd_ready), 32'd0);
      checkOutput("rst_o_cmd_valid", 32'(o_icb_cmd_valid), 32'd0);
      checkOutput("rst_excl_ok", 32'(icb_rsp_excl_ok), 32'd0);
    end else begin
      m_pop = o_icb_rsp_valid && icb_rsp_ready && (mq.size() > 0);
      m_acc = (mq.size() < OST_DP) || m_pop;
      m_hs  = icb_cmd_valid && o_icb_cmd_ready && m_acc;
      m_rd  = icb_cmd_read;
      m_ex  = icb_cmd_excl;
      m_id  = int'(icb_cmd_id);
      m_g   = icb_cmd_addr[31:2];
      m_sct = m_ex && !m_rd && (m_id < NUM_MST) && m_valid[m_id] && (m_gran[m_id] == m_g);
      checkOutput("cmd_ready", 32'(icb_cmd_ready), 32'(o_icb_cmd_ready && m_acc));
      checkOutput("o_cmd_valid", 32'(o_icb_cmd_valid), 32'(icb_cmd_valid && m_acc));
      checkOutput("o_cmd_wmask", 32'(o_icb_cmd_wmask),
                  (m_ex && !m_rd && !m_sct) ? 32'd0 : 32'(icb_cmd_wmask));
      checkOutput("o_cmd_addr", o_icb_cmd_addr, icb_cmd_addr);
      checkOutput("o_cmd_wdata", o_icb_cmd_wdata, icb_cmd_wdata);
      checkOutput("o_rsp_ready", 32'(o_icb_rsp_ready), 32'(icb_rsp_ready));
      checkOutput("rsp_err", 32'(icb_rsp_err), 32'(o_icb_rsp_err));
      checkOutput("rsp_rdata", icb_rsp_rdata, o_icb_rsp_rdata);
      if (o_icb_rsp_valid) begin
        checkOutput("excl_ok", 32'(icb_rsp_excl_ok),
                    (mq.size() > 0) ? 32'(mq[0] && !o_icb_rsp_err) : 32'd0);
      end
      @(posedge clk);
      if (rst_n) begin
`ifdef N101_EXCL_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
          if (m_valid[i]) begin
            if (m_age[i] == TMO_CYC - 1) m_valid[i] = 1'b0;
            else m_age[i]++;
          end
        end
`endif
        if (m_pop) void'(mq.pop_front());
        if (m_hs) begin
          mq.push_back(m_sct);
          if (!m_rd && (!m_ex || m_sct)) begin
            for (int i = 0; i < 4; i++) if (m_valid[i] && m_gran[i] == m_g) m_valid[i] = 1'b0;
          end
          if (m_ex && !m_rd && m_id < NUM_MST) m_valid[m_id] = 1'b0;
          if (m_ex && m_rd && m_id < NUM_MST) begin
            m_valid[m_id] = 1'b1;
            m_gran[m_id]  = m_g;
            m_age[m_id]   = 0;
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    icb_cmd_valid = 0; icb_cmd_read = 0; icb_cmd_excl = 0; icb_cmd_addr = 0;
    icb_cmd_id = 0; icb_cmd_wmask = 0; icb_cmd_wdata = 0; icb_cmd_lock = 0;
    icb_cmd_size = 0; o_icb_cmd_ready = 1; o_icb_rsp_valid = 0; icb_rsp_ready = 1;
    o_icb_rsp_err = 0; o_icb_rsp_rdata = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle();

    // m0 LR then SC on the same granule succeeds, and the SC consumes the entry
    cmd(1, 1, 32'h100, 2'd0, 4'hf); #1 checkOutput("a_lr_ready", 32'(icb_cmd_ready), 32'd1);
    cmd(0, 1, 32'h100, 2'd0, 4'hf); #1 checkOutput("a_sc_wmask", 32'(o_icb_cmd_wmask), 32'hf);
    rsp(0); #1 checkOutput("a_lr_ok", 32'(icb_rsp_excl_ok), 32'd0);
    rsp(0); #1 checkOutput("a_sc_ok", 32'(icb_rsp_excl_ok), 32'd1);
    cmd(0, 1, 32'h100, 2'd0, 4'hf); #1 checkOutput("a_sc2_wmask", 32'(o_icb_cmd_wmask), 32'h0);
    rsp(0); #1 checkOutput("a_sc2_ok", 32'(icb_rsp_excl_ok), 32'd0);

    // another master's plain write into the granule kills m0's reservation
    cmd(1, 1, 32'h100, 2'd0, 4'hf);
    cmd(0, 0, 32'h102, 2'd1, 4'h3); #1 checkOutput("b_wr_wmask", 32'(o_icb_cmd_wmask), 32'h3);
    rsp(0); rsp(0);
    cmd(0, 1, 32'h100, 2'd0, 4'hf); #1 checkOutput("b_sc_wmask", 32'(o_icb_cmd_wmask), 32'h0);
    rsp(0); #1 checkOutput("b_sc_ok", 32'(icb_rsp_excl_ok), 32'd0);

    // m1's successful SC clears m0's overlapping reservation
    cmd(1, 1, 32'h100, 2'd0, 4'hf);
    cmd(1, 1, 32'h100, 2'd1, 4'hf);
    rsp(0); rsp(0);
    cmd(0, 1, 32'h100, 2'd1, 4'hf); #1 checkOutput("c_m1_wmask", 32'(o_icb_cmd_wmask), 32'hf);
    cmd(0, 1, 32'h100, 2'd0, 4'hf); #1 checkOutput("c_m0_wmask", 32'(o_icb_cmd_wmask), 32'h0);
    rsp(0); #1 checkOutput("c_m1_ok", 32'(icb_rsp_excl_ok), 32'd1);
    rsp(0); #1 checkOutput("c_m0_ok", 32'(icb_rsp_excl_ok), 32'd0);

    // third command stalls until a response pops a flag; flags stay ordered
    cmd(1, 1, 32'h200, 2'd1, 4'hf);
    cmd(0, 1, 32'h200, 2'd1, 4'hf);
    cmd(1, 0, 32'h040, 2'd0, 4'hf); #1 checkOutput("d_stall1", 32'(icb_cmd_ready), 32'd0);
    cmd(1, 0, 32'h040, 2'd0, 4'hf); #1 checkOutput("d_stall2", 32'(o_icb_cmd_valid), 32'd0);
    applyStimulus(1, 1, 0, 32'h040, 2'd0, 4'hf, 1, 1, 1, 0);
    #1 checkOutput("d_pop_ready", 32'(icb_cmd_ready), 32'd1);
    checkOutput("d_ok0", 32'(icb_rsp_excl_ok), 32'd0);
    rsp(0); #1 checkOutput("d_ok1", 32'(icb_rsp_excl_ok), 32'd1);
    rsp(0); #1 checkOutput("d_ok2", 32'(icb_rsp_excl_ok), 32'd0);

    // a true SC answered with an error must not report excl_ok
    cmd(1, 1, 32'h300, 2'd2, 4'hf);
    cmd(0, 1, 32'h300, 2'd2, 4'hf);
    rsp(0);
    rsp(1); #1 checkOutput("e_err", 32'(icb_rsp_err), 32'd1);
    checkOutput("e_ok", 32'(icb_rsp_excl_ok), 32'd0);

    // reset with two flags outstanding: flags lost, reservations gone
    cmd(1, 1, 32'h100, 2'd0, 4'hf);
    cmd(1, 1, 32'h104, 2'd1, 4'hf);
    rsp(0); rsp(0);
    cmd(1, 1, 32'h200, 2'd2, 4'hf);
    rsp(0);
    cmd(0, 1, 32'h200, 2'd2, 4'hf);
    cmd(1, 1, 32'h100, 2'd0, 4'hf);
    idle(); rst_n = 1'b0;
    idle(); #1 checkOutput("f_rst_ready", 32'(icb_cmd_ready), 32'd0);
    idle(); rst_n = 1'b1;
    rsp(0); #1 checkOutput("f_stale_ok", 32'(icb_rsp_excl_ok), 32'd0);
    cmd(0, 1, 32'h100, 2'd0, 4'hf); #1 checkOutput("f_m0_wmask", 32'(o_icb_cmd_wmask), 32'h0);
    cmd(0, 1, 32'h104, 2'd1, 4'hf); #1 checkOutput("f_m1_wmask", 32'(o_icb_cmd_wmask), 32'h0);
    rsp(0); rsp(0);

    // SC from an id without an entry is always false
    cmd(1, 1, 32'h100, 2'd3, 4'hf);
    cmd(0, 1, 32'h100, 2'd3, 4'hf); #1 checkOutput("g_bad_id_wmask", 32'(o_icb_cmd_wmask), 32'h0);
    rsp(0); rsp(0);

`ifdef N101_EXCL_TIMEOUT_EN
    cmd(1, 1, 32'h200, 2'd2, 4'hf);
    rsp(0);
    repeat (60) idle();
    cmd(0, 1, 32'h200, 2'd2, 4'hf); #1 checkOutput("t_sc62_wmask", 32'(o_icb_cmd_wmask), 32'hf);
    rsp(0); #1 checkOutput("t_sc62_ok", 32'(icb_rsp_excl_ok), 32'd1);
    cmd(1, 1, 32'h200, 2'd2, 4'hf);
    rsp(0);
    repeat (63) idle();
    cmd(0, 1, 32'h200, 2'd2, 4'hf); #1 checkOutput("t_sc65_wmask", 32'(o_icb_cmd_wmask), 32'h0);
    rsp(0); #1 checkOutput("t_sc65_ok", 32'(icb_rsp_excl_ok), 32'd0);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] base;
      case ($urandom_range(0, 2))
        0:       base = 32'h100;
        1:       base = 32'h104;
        default: base = 32'h200;
      endcase
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), base + 32'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 4'($urandom), 1'($urandom_range(0, 4) != 0),
                    (mq.size() > 0) && ($urandom_range(0, 9) < 6),
                    1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) == 0));
      rst_n = ($urandom_range(0, 399) != 0);
    end
    rst_n = 1'b1;
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
